piano_key_ctrl: RTL and testbench
=================================

PIANO_KEY_CTRL -- requirements
Module: piano_key_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16: number of consecutive clk cycles a synchronized button level must stay stable before it is accepted.
REQ-002 Parameter SCAN_CYCLES, default 8: number of clk cycles each display digit stays selected.
REQ-003 clk  in  1  single system clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 key  in  7  raw note keys, active-high: bit0=c, bit1=d, bit2=e, bit3=f, bit4=g, bit5=a, bit6=b.
REQ-006 btn_up  in  1  raw octave-up button, active-high.
REQ-007 btn_down  in  1  raw octave-down button, active-high.
REQ-008 note_valid  out  1  high while a note is granted.
REQ-009 note_code  out  3  granted note (0=c … 6=b); 7 is never driven.
REQ-010 octave  out  2  current octave: 0=LOW, 1=MID, 2=HIGH; 3 is never driven.
REQ-011 up_flag  out  1  high when octave==2.
REQ-012 down_flag  out  1  high when octave==0.
REQ-013 seg  out  7  segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
REQ-014 dig_sel  out  2  one-hot active-high digit select: 01=note digit, 10=octave digit.

Function
REQ-015 key, btn_up and btn_down shall each pass through a 2-flop synchronizer before any other use.
REQ-016 Each synchronized button shall have its own debounce counter, cleared on any level change; the debounced level shall update when the counter reaches DEB_CYCLES-1 with the level still unchanged.
REQ-017 A 0->1 transition of a debounced button shall produce one step pulse lasting one cycle; holding the button shall produce no further pulses.
REQ-018 An up step shall increment octave, saturating at 2; a down step shall decrement octave, saturating at 0.
REQ-019 Up and down steps in the same cycle shall both be ignored, leaving octave unchanged.
REQ-020 The note arbiter shall be an FSM with three states: IDLE, HOLD, REL.
REQ-021 IDLE: if any synchronized key is high, latch the lowest-index high key into note_code, set note_valid=1, and go to HOLD; otherwise stay in IDLE.
REQ-022 HOLD: note_code shall not change while the latched key stays high, even when other keys are pressed or released.
REQ-023 HOLD: when the latched key goes low, clear note_valid and go to REL.
REQ-024 REL: unconditionally go to IDLE after one cycle; re-arbitration among still-held keys therefore occurs no earlier than 2 cycles after release.
REQ-025 Latency from a raw key rising edge (no other keys held, arbiter in IDLE) to note_valid=1 shall be 3 clk cycles.
REQ-026 note_code shall hold its last value while note_valid=0.
REQ-027 The scan counter shall toggle dig_sel between 01 and 10 every SCAN_CYCLES cycles.
REQ-028 Note digit (dig_sel=01), registered from note_code: c=0111001, d=1011110, e=1111001, f=1110001, g=1101111, a=1110111, b=1111100.
REQ-029 Note digit when note_valid=0: seg=0000000 (blank).
REQ-030 Octave digit (dig_sel=10): 0=0111111, 1=0000110, 2=1011011.
REQ-031 seg and dig_sel shall change in the same cycle, so no mismatched digit/pattern pair ever appears.

Reset
REQ-032 While rst=1 (asynchronous): octave=1, note_valid=0, note_code=0, up_flag=0, down_flag=0, dig_sel=01, seg=0000000.
REQ-033 While rst=1 (asynchronous): arbiter in IDLE; synchronizers, debounce counters, debounced levels and scan counter cleared.
REQ-034 Reset asserted mid-press or mid-debounce shall discard the pending press; after release of reset, a held button shall need the full DEB_CYCLES again, and is accepted as a new press.

Verification
REQ-035 Scenario 1: reset, then raw key=0000100 -> note_valid=1, note_code=2 exactly 3 cycles later; at the next note digit, seg=1111001.
REQ-036 Scenario 2: hold e, then press c, then release e -> note_code stays 2 until e releases; note_valid=0 for 2 cycles; then note_code=0.
REQ-037 Scenario 3: btn_up held 3 x (DEB_CYCLES+4) cycles with bounce (1-cycle glitches) at each edge -> octave 1->2 once only; up_flag=1; a further press leaves octave=2.
REQ-038 Scenario 4: btn_up and btn_down debounced edges in the same cycle -> octave unchanged; three clean down presses -> octave=0, down_flag=1.
REQ-039 Scenario 5: SCAN_CYCLES=8, idle, octave=1 -> dig_sel alternates 01/10 every 8 cycles; seg alternates 0000000/0000110.
REQ-040 Scenario 6: assert rst while in HOLD with btn_down mid-debounce -> all outputs at reset values immediately; after release, octave=1 and one clean press is needed to step.

Source files
------------

// File: rtl/piano_key_ctrl.sv
// Piano key controller: synchronizes and debounces inputs, arbitrates one note,
// tracks the octave and multiplexes a two-digit seven-segment display.
module piano_key_ctrl #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned SCAN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] key,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       note_valid,
  output logic [2:0] note_code,
  output logic [1:0] octave,
  output logic       up_flag,
  output logic       down_flag,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);

  localparam int unsigned DebW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned ScanW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DebW-1:0]  DebMax  = DebW'(DEB_CYCLES - 1);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRel} state_e;

  // Two-flop synchronizers: {btn_down, btn_up, key}
  logic [8:0] sync1, sync2;
  logic [6:0] key_s;
  logic [1:0] btn_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_down, btn_up, key};
      sync2 <= sync1;
    end
  end

  assign key_s = sync2[6:0];
  assign btn_s = sync2[8:7];

  // Debounce: index 0 = up, 1 = down
  logic [1:0]      btn_last, btn_deb, btn_deb_q, step;
  logic [DebW-1:0] deb_cnt [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_last  <= '0;
      btn_deb   <= '0;
      btn_deb_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      btn_deb_q <= btn_deb;
      for (int i = 0; i < 2; i++) begin
        btn_last[i] <= btn_s[i];
        if (btn_s[i] != btn_last[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DebMax) begin
          btn_deb[i] <= btn_s[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign step = btn_deb & ~btn_deb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      octave <= 2'd1;
    end else if (step[0] && !step[1] && octave != 2'd2) begin
      octave <= octave + 2'd1;
    end else if (step[1] && !step[0] && octave != 2'd0) begin
      octave <= octave - 2'd1;
    end
  end

  assign up_flag   = (octave == 2'd2);
  assign down_flag = (octave == 2'd0);

  // Lowest-index pressed key wins
  logic [2:0] first_key;
  always_comb begin
    first_key = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (key_s[i]) first_key = 3'(i);
    end
  end

  state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      note_valid <= 1'b0;
      note_code  <= 3'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (|key_s) begin
            note_code  <= first_key;
            note_valid <= 1'b1;
            state      <= StHold;
          end
        end
        StHold: begin
          if (!key_s[note_code]) begin
            note_valid <= 1'b0;
            state      <= StRel;
          end
        end
        StRel:   state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Display: seg is computed for the next dig_sel so both change together
  logic [ScanW-1:0] scan_cnt;
  logic [1:0]       dig_sel_d;
  logic [6:0]       note_seg, oct_seg, seg_d;

  always_comb begin
    note_seg = 7'b0000000;
    if (note_valid) begin
      case (note_code)
        3'd0:    note_seg = 7'b0111001;
        3'd1:    note_seg = 7'b1011110;
        3'd2:    note_seg = 7'b1111001;
        3'd3:    note_seg = 7'b1110001;
        3'd4:    note_seg = 7'b1101111;
        3'd5:    note_seg = 7'b1110111;
        3'd6:    note_seg = 7'b1111100;
        default: note_seg = 7'b0000000;
      endcase
    end
  end

  always_comb begin
    case (octave)
      2'd0:    oct_seg = 7'b0111111;
      2'd1:    oct_seg = 7'b0000110;
      2'd2:    oct_seg = 7'b1011011;
      default: oct_seg = 7'b0000000;
    endcase
  end

  always_comb begin
    dig_sel_d = dig_sel;
    if (scan_cnt == ScanMax) dig_sel_d = {dig_sel[0], dig_sel[1]};
    seg_d = dig_sel_d[0] ? note_seg : oct_seg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_sel  <= 2'b01;
      seg      <= 7'b0000000;
    end else begin
      scan_cnt <= (scan_cnt == ScanMax) ? '0 : scan_cnt + 1'b1;
      dig_sel  <= dig_sel_d;
      seg      <= seg_d;
    end
  end

endmodule

// File: tb/tb_piano_key_ctrl.sv
// Directed self-checking bench for piano_key_ctrl with default parameters.
module tb_piano_key_ctrl;

  localparam int unsigned Deb = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] key = '0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       note_valid, up_flag, down_flag;
  logic [2:0] note_code;
  logic [1:0] octave, dig_sel;
  logic [6:0] seg;

  int n_checks = 0;
  int n_errors = 0;

  piano_key_ctrl #(.DEB_CYCLES(16), .SCAN_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .note_valid (note_valid),
    .note_code  (note_code),
    .octave     (octave),
    .up_flag    (up_flag),
    .down_flag  (down_flag),
    .seg        (seg),
    .dig_sel    (dig_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_dig(input logic [1:0] want);
    int n = 0;
    while (dig_sel !== want && n < 40) begin
      tick();
      n++;
    end
    check("wait_dig", 32'(dig_sel), 32'(want));
  endtask

  // Press and release buttons, optionally with 1-cycle glitches at each edge.
  // Returns how many times octave changed during the whole press.
  task automatic press_btn(input logic u, input logic d, input bit bounce, output int changes);
    logic [1:0] prev;
    changes = 0;
    prev = octave;
    for (int ph = 0; ph < 8 + 3 * (Deb + 4) + Deb + 8; ph++) begin
      logic lvl;
      if (ph < 4)                        lvl = bounce ? ph[0] == 1'b0 : 1'b1;
      else if (ph < 4 + 3 * (Deb + 4))   lvl = 1'b1;
      else if (ph < 8 + 3 * (Deb + 4))   lvl = bounce ? ph[0] == 1'b0 : 1'b0;
      else                               lvl = 1'b0;
      btn_up   = u & lvl;
      btn_down = d & lvl;
      tick();
      if (octave !== prev) changes++;
      prev = octave;
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  int changes;

  initial begin
    // Reset values
    rst = 1'b1;
    #2;
    check("rst_octave", 32'(octave), 32'd1);
    check("rst_valid", 32'(note_valid), 32'd0);
    check("rst_code", 32'(note_code), 32'd0);
    check("rst_flags", 32'({up_flag, down_flag}), 32'd0);
    check("rst_dig", 32'(dig_sel), 32'b01);
    check("rst_seg", 32'(seg), 32'd0);
    tick(2);
    rst = 1'b0;

    // Scenario 5: idle scan, 8 cycles per digit
    for (int k = 1; k <= 24; k++) begin
      tick();
      check("scan_dig", 32'(dig_sel), ((k / 8) % 2) ? 32'b10 : 32'b01);
      check("scan_seg", 32'(seg), ((k / 8) % 2) ? 32'b0000110 : 32'b0000000);
    end

    // Scenario 1: key e, 3-cycle latency, then note digit shows e
    do_reset();
    key = 7'b0000100;
    tick(2);
    check("s1_lat2", 32'(note_valid), 32'd0);
    tick();
    check("s1_lat3", 32'(note_valid), 32'd1);
    check("s1_code", 32'(note_code), 32'd2);
    wait_dig(2'b10);
    wait_dig(2'b01);
    check("s1_seg", 32'(seg), 32'b1111001);

    // Scenario 2: add c while e held, then release e
    key = 7'b0000101;
    tick(6);
    check("s2_hold_v", 32'(note_valid), 32'd1);
    check("s2_hold_c", 32'(note_code), 32'd2);
    key = 7'b0000001;
    tick(3);
    check("s2_rel1_v", 32'(note_valid), 32'd0);
    check("s2_rel1_c", 32'(note_code), 32'd2);
    tick();
    check("s2_rel2_v", 32'(note_valid), 32'd0);
    tick();
    check("s2_new_v", 32'(note_valid), 32'd1);
    check("s2_new_c", 32'(note_code), 32'd0);
    key = '0;
    tick(6);
    check("s2_off", 32'(note_valid), 32'd0);

    // Scenario 3: bouncy up press steps once; further press saturates
    press_btn(1'b1, 1'b0, 1'b1, changes);
    check("s3_oct", 32'(octave), 32'd2);
    check("s3_once", 32'(changes), 32'd1);
    check("s3_upf", 32'(up_flag), 32'd1);
    press_btn(1'b1, 1'b0, 1'b1, changes);
    check("s3_sat", 32'(octave), 32'd2);
    check("s3_sat_chg", 32'(changes), 32'd0);

    // Scenario 4: simultaneous up/down ignored, then three downs
    press_btn(1'b1, 1'b1, 1'b0, changes);
    check("s4_both", 32'(octave), 32'd2);
    check("s4_both_chg", 32'(changes), 32'd0);
    press_btn(1'b0, 1'b1, 1'b0, changes);
    check("s4_down1", 32'(octave), 32'd1);
    press_btn(1'b0, 1'b1, 1'b0, changes);
    check("s4_down2", 32'(octave), 32'd0);
    press_btn(1'b0, 1'b1, 1'b0, changes);
    check("s4_down3", 32'(octave), 32'd0);
    check("s4_downf", 32'(down_flag), 32'd1);
    check("s4_upf", 32'(up_flag), 32'd0);

    // Scenario 6: reset during HOLD with btn_down mid-debounce
    key = 7'b0000100;
    tick(5);
    check("s6_hold", 32'(note_valid), 32'd1);
    btn_down = 1'b1;
    tick(8);
    rst = 1'b1;
    #1;
    check("s6_async_v", 32'(note_valid), 32'd0);
    check("s6_async_c", 32'(note_code), 32'd0);
    check("s6_async_oct", 32'(octave), 32'd1);
    check("s6_async_flags", 32'({up_flag, down_flag}), 32'd0);
    check("s6_async_dig", 32'(dig_sel), 32'b01);
    check("s6_async_seg", 32'(seg), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(12);
    check("s6_no_step", 32'(octave), 32'd1);
    tick(18);
    check("s6_step", 32'(octave), 32'd0);
    btn_down = 1'b0;
    key = '0;
    tick(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
